mix_columns_iter: RTL

Iterative forward AES-128 MixColumns engine. It accepts a 128-bit state over a valid/ready handshake and processes `COLS_PER_CYCLE` columns per clock. It holds the result until it is consumed. The block sits in the encryption round datapath between ShiftRows and AddRoundKey, and is the forward counterpart of the decryption-side inverse MixColumns.

---
 rtl/mix_columns_iter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES-128 forward MixColumns engine that
// computes COLS_PER_CYCLE columns per clock between two valid/ready ports.
// Ports: clk; rst_n (synchronous, active-low);
//        state_in/in_valid/in_ready: 128-bit state intake;
//        state_out/out_valid/out_ready: 128-bit result, held until taken;
//        busy: high from accept until the result is consumed.
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] state_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] state_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 ||
          COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // One-hot so out_valid comes straight off a flop.
    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_BUSY = 3'b010;
    localparam logic [2:0] S_DONE = 3'b100;

    // With 4 lanes the step is 4, which is 0 in a 2-bit counter.
    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_OFF = 2'(COLS_PER_CYCLE - 1);

    logic [2:0]   st_q;
    logic [2:0]   st_d;
    logic [1:0]   cnt_q;
    logic [127:0] state_q;
    logic [127:0] out_q;
    logic         accept;
    logic         last_col;

    logic [1:0]   col_idx [COLS_PER_CYCLE];
    logic [31:0]  col_res [COLS_PER_CYCLE];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shared-sum form: t = s0^s1^s2^s3, then each output adds
    // its own byte back and doubles a neighbouring pair.
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] s3;
        logic [7:0] t;
        logic [7:0] o0;
        logic [7:0] o1;
        logic [7:0] o2;
        logic [7:0] o3;
        s0 = c[7:0];
        s1 = c[15:8];
        s2 = c[23:16];
        s3 = c[31:24];
        t  = s0 ^ s1 ^ s2 ^ s3;
        o0 = t ^ s0 ^ xtime(s0 ^ s1);
        o1 = t ^ s1 ^ xtime(s1 ^ s2);
        o2 = t ^ s2 ^ xtime(s2 ^ s3);
        o3 = t ^ s3 ^ xtime(s3 ^ s0);
        return {o3, o2, o1, o0};
    endfunction

    assign accept   = in_valid & in_ready;
    assign last_col = st_q[1] && ((cnt_q + LAST_OFF) == 2'd3);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q <= S_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    // FSM: next state
    always_comb begin
        st_d = st_q;
        unique case (1'b1)
            st_q[0]: if (accept)    st_d = S_BUSY;
            st_q[1]: if (last_col)  st_d = S_DONE;
            st_q[2]: if (out_ready) st_d = S_IDLE;
            default:                st_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = st_q[0] & rst_n;
        busy      = ~st_q[0];
        out_valid = st_q[2];
    end

    assign state_out = out_q;

    // Column lanes for this cycle.
    always_comb begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col_idx[k] = cnt_q + 2'(k);
            col_res[k] = mix_col(state_q[{col_idx[k], 5'b0} +: 32]);
        end
    end

    // Datapath: input latch, column counter, result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else if (accept) begin
            state_q <= state_in;
            cnt_q   <= '0;
        end else if (st_q[1]) begin
            cnt_q <= cnt_q + STEP;
            for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                out_q[{col_idx[k], 5'b0} +: 32] <= col_res[k];
            end
        end
    end

endmodule
